class_pio_master: RTL and testbench
===================================

Name: class_pio_master

Overview:
- Initiator end of the classifier PIO port.
- Converts single register-access requests from a host (CPU bridge or testbench) into the classifier's multiplexed address/data PIO protocol: pio_start, pio_rw, pio_addr_wdata out; pio_ack, pio_rvalid, pio_rdata in.
- Paces all PIO activity to the responder-supplied clk_div.
- Returns read data, or a timeout error, on a one-cycle response strobe.

Parameters:
- PIO_NBITS, 32, width of the multiplexed address/write-data bus and of read data.
- TIMEOUT_TICKS, 255, number of clk_div ticks to wait for ack/rvalid before declaring an error; must be >= 1.
- TO_WIDTH, $clog2(TIMEOUT_TICKS+1), timeout counter width (derived).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- req_vld  input  1  host request valid.
- req_rdy  output  1  master idle and able to accept a request.
- req_rw  input  1  1 = write, 0 = read.
- req_addr  input  PIO_NBITS  register address.
- req_wdata  input  PIO_NBITS  write data (ignored for reads).
- rsp_vld  output  1  one-cycle response strobe.
- rsp_err  output  1  qualifies rsp_vld; 1 = timeout.
- rsp_rdata  output  PIO_NBITS  read data, qualified by rsp_vld.
- pio_start  output  1  PIO transaction start, address phase.
- pio_rw  output  1  PIO direction, 1 = write.
- pio_addr_wdata  output  PIO_NBITS  address in the start phase, write data in the following phase.
- clk_div  input  1  divided pacing clock from the classifier, treated as a level and sampled in the clk domain.
- pio_ack  input  1  responder acknowledge.
- pio_rvalid  input  1  read data valid.
- pio_rdata  input  PIO_NBITS  read data.

Behaviour:
- The clock port is clk. Reset is rst, synchronous and active-high. All flops update on posedge clk only.
- Reset values:
  - req_rdy=0 during rst, 1 on the first cycle after rst deasserts.
  - rsp_vld=0, rsp_err=0, rsp_rdata=0.
  - pio_start=0, pio_rw=0, pio_addr_wdata=0.
  - clk_div_q=0, timeout counter=0, state=IDLE.
- Tick generation:
  - tick = clk_div & ~clk_div_q, with clk_div_q registered every cycle.
  - If clk_div is high in the first cycle after reset, that cycle is a tick.
  - All PIO outputs change, and all PIO inputs are sampled, only in tick cycles.
- Request acceptance:
  - Handshake is req_vld & req_rdy.
  - req_rdy=1 only in IDLE. On handshake, rw, addr and wdata are captured and the state moves to ADDR.
- States:
  - IDLE: outputs idle, pio_start=0.
  - ADDR: on the next tick, drive pio_start=1, pio_rw=rw, pio_addr_wdata=addr; go to DATA.
  - DATA: on the next tick, drive pio_start=0. For a write, drive pio_addr_wdata=wdata; for a read, hold the address. Clear the counter; go to WAIT_ACK.
  - WAIT_ACK, on each tick:
    - pio_ack=1 and write: go to RESP with err=0.
    - pio_ack=1 and read, with pio_rvalid=1 on the same tick: capture pio_rdata, go to RESP.
    - pio_ack=1 and read, pio_rvalid=0: go to WAIT_RDATA with the counter cleared.
    - Otherwise increment the counter.
  - WAIT_RDATA, on each tick:
    - pio_rvalid=1: capture pio_rdata, go to RESP.
    - Otherwise increment the counter.
  - Timeout: a tick in WAIT_ACK or WAIT_RDATA on which the counter equals TIMEOUT_TICKS-1 and the awaited signal is low → RESP with err=1 and rdata=0.
  - RESP: rsp_vld=1 for exactly one clk cycle; pio_addr_wdata returns to 0; next state IDLE. Ticks are ignored.
- PIO output hold:
  - pio_start is high for exactly one tick period, from the ADDR tick to the DATA tick.
  - pio_addr_wdata is stable between ticks.
- pio_ack/pio_rvalid asserted outside the wait states are ignored.
- For a write, rsp_rdata=0.
- Timing:
  - Latency is at least 4 clk from handshake to rsp_vld when clk_div toggles every cycle.
  - The earliest back-to-back request is accepted the cycle after rsp_vld.
- rst asserted mid-transaction: abort immediately to reset values; no response is issued.

Test Plan:
- Write, addr=0x0000_0010, wdata=0xDEAD_BEEF, clk_div toggling every 2 clk, ack on the 2nd WAIT_ACK tick → pio_start=1 with bus=0x10 for one tick, then bus=0xDEADBEEF, pio_rw=1; rsp_vld=1, rsp_err=0, rsp_rdata=0.
- Read, addr=0x24, ack tick then rvalid 3 ticks later with pio_rdata=0x1234_5678 → rsp_rdata=0x12345678, rsp_err=0, req_rdy=0 throughout until the cycle after rsp_vld.
- Read with ack and rvalid on the same tick, rdata=0xA5A5_A5A5 → skips WAIT_RDATA; response on the next clk with 0xA5A5A5A5.
- Timeout with TIMEOUT_TICKS=4, no ack → rsp_vld on the 4th WAIT_ACK tick, rsp_err=1, rsp_rdata=0; a subsequent write completes normally.
- clk_div held high for 10 clk then low → no extra ticks; FSM does not advance during the hold.
- Reset in WAIT_RDATA → next cycle all outputs 0, no rsp_vld; req_rdy=1 after rst drops; a later ack/rvalid is ignored.

Source files
------------

// File: rtl/class_pio_master.sv
// Initiator side of the classifier PIO port: turns single host register accesses into
// tick-paced start/address/data phases and returns read data or a timeout error.
module class_pio_master #(
    parameter int PIO_NBITS     = 32,
    parameter int TIMEOUT_TICKS = 255,
    parameter int TO_WIDTH      = $clog2(TIMEOUT_TICKS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_vld,
    output logic                 req_rdy,
    input  logic                 req_rw,
    input  logic [PIO_NBITS-1:0] req_addr,
    input  logic [PIO_NBITS-1:0] req_wdata,
    output logic                 rsp_vld,
    output logic                 rsp_err,
    output logic [PIO_NBITS-1:0] rsp_rdata,
    output logic                 pio_start,
    output logic                 pio_rw,
    output logic [PIO_NBITS-1:0] pio_addr_wdata,
    input  logic                 clk_div,
    input  logic                 pio_ack,
    input  logic                 pio_rvalid,
    input  logic [PIO_NBITS-1:0] pio_rdata
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ADDR       = 3'd1,
        ST_DATA       = 3'd2,
        ST_WAIT_ACK   = 3'd3,
        ST_WAIT_RDATA = 3'd4,
        ST_RESP       = 3'd5
    } state_t;

    localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT_TICKS - 1);

    state_t                r_state;
    state_t                w_state_d;
    logic                  r_clk_div_q;
    logic                  w_tick;
    logic                  w_hs;
    logic [TO_WIDTH-1:0]   r_cnt;
    logic [TO_WIDTH-1:0]   w_cnt_d;
    logic                  r_rw;
    logic [PIO_NBITS-1:0]  r_addr;
    logic [PIO_NBITS-1:0]  r_wdata;
    logic                  r_req_rdy;
    logic                  r_rsp_vld;
    logic                  w_rsp_vld_d;
    logic                  r_rsp_err;
    logic                  w_rsp_err_d;
    logic [PIO_NBITS-1:0]  r_rsp_rdata;
    logic [PIO_NBITS-1:0]  w_rsp_rdata_d;
    logic                  r_pio_start;
    logic                  w_pio_start_d;
    logic                  r_pio_rw;
    logic                  w_pio_rw_d;
    logic [PIO_NBITS-1:0]  r_pio_aw;
    logic [PIO_NBITS-1:0]  w_pio_aw_d;
    logic                  w_done;
    logic                  w_err;
    logic [PIO_NBITS-1:0]  w_rdata;

    // clk_div is a level from another domain's divider; only its rising edge paces us
    assign w_tick = clk_div & ~r_clk_div_q;
    assign w_hs   = req_vld & r_req_rdy;

    assign req_rdy        = r_req_rdy;
    assign rsp_vld        = r_rsp_vld;
    assign rsp_err        = r_rsp_err;
    assign rsp_rdata      = r_rsp_rdata;
    assign pio_start      = r_pio_start;
    assign pio_rw         = r_pio_rw;
    assign pio_addr_wdata = r_pio_aw;

    // Next-state and next-output decode; every wait-state decision happens on a tick only
    always_comb begin
        w_state_d     = r_state;
        w_cnt_d       = r_cnt;
        w_pio_start_d = r_pio_start;
        w_pio_rw_d    = r_pio_rw;
        w_pio_aw_d    = r_pio_aw;
        w_rsp_vld_d   = 1'b0;
        w_rsp_err_d   = r_rsp_err;
        w_rsp_rdata_d = r_rsp_rdata;
        w_done        = 1'b0;
        w_err         = 1'b0;
        w_rdata       = {PIO_NBITS{1'b0}};
        case (r_state)
            ST_IDLE: begin
                if (w_hs) begin
                    w_state_d = ST_ADDR;
                end else begin
                    w_state_d = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (w_tick) begin
                    w_pio_start_d = 1'b1;
                    w_pio_rw_d    = r_rw;
                    w_pio_aw_d    = r_addr;
                    w_state_d     = ST_DATA;
                end else begin
                    w_state_d = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    w_pio_start_d = 1'b0;
                    w_pio_aw_d    = r_rw ? r_wdata : r_addr;
                    w_cnt_d       = {TO_WIDTH{1'b0}};
                    w_state_d     = ST_WAIT_ACK;
                end else begin
                    w_state_d = ST_DATA;
                end
            end
            ST_WAIT_ACK: begin
                if (w_tick) begin
                    if (pio_ack) begin
                        if (r_rw) begin
                            w_done = 1'b1;
                        end else if (pio_rvalid) begin
                            w_done  = 1'b1;
                            w_rdata = pio_rdata;
                        end else begin
                            w_cnt_d   = {TO_WIDTH{1'b0}};
                            w_state_d = ST_WAIT_RDATA;
                        end
                    end else if (r_cnt == TO_LAST) begin
                        w_done = 1'b1;
                        w_err  = 1'b1;
                    end else begin
                        w_cnt_d = r_cnt + TO_WIDTH'(1);
                    end
                end else begin
                    w_state_d = ST_WAIT_ACK;
                end
            end
            ST_WAIT_RDATA: begin
                if (w_tick) begin
                    if (pio_rvalid) begin
                        w_done  = 1'b1;
                        w_rdata = pio_rdata;
                    end else if (r_cnt == TO_LAST) begin
                        w_done = 1'b1;
                        w_err  = 1'b1;
                    end else begin
                        w_cnt_d = r_cnt + TO_WIDTH'(1);
                    end
                end else begin
                    w_state_d = ST_WAIT_RDATA;
                end
            end
            ST_RESP: begin
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
        // Completion (success or timeout) always funnels through the one-cycle RESP state
        if (w_done) begin
            w_state_d     = ST_RESP;
            w_rsp_vld_d   = 1'b1;
            w_rsp_err_d   = w_err;
            w_rsp_rdata_d = w_rdata;
            w_pio_aw_d    = {PIO_NBITS{1'b0}};
        end else begin
            w_rsp_vld_d = 1'b0;
        end
    end

    // State, request capture and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_clk_div_q <= 1'b0;
            r_cnt       <= {TO_WIDTH{1'b0}};
            r_rw        <= 1'b0;
            r_addr      <= {PIO_NBITS{1'b0}};
            r_wdata     <= {PIO_NBITS{1'b0}};
            r_req_rdy   <= 1'b0;
            r_rsp_vld   <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= {PIO_NBITS{1'b0}};
            r_pio_start <= 1'b0;
            r_pio_rw    <= 1'b0;
            r_pio_aw    <= {PIO_NBITS{1'b0}};
        end else begin
            r_state     <= w_state_d;
            r_clk_div_q <= clk_div;
            r_cnt       <= w_cnt_d;
            r_req_rdy   <= (w_state_d == ST_IDLE);
            r_rsp_vld   <= w_rsp_vld_d;
            r_rsp_err   <= w_rsp_err_d;
            r_rsp_rdata <= w_rsp_rdata_d;
            r_pio_start <= w_pio_start_d;
            r_pio_rw    <= w_pio_rw_d;
            r_pio_aw    <= w_pio_aw_d;
            if (w_hs) begin
                r_rw    <= req_rw;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end else begin
                r_rw    <= r_rw;
                r_addr  <= r_addr;
                r_wdata <= r_wdata;
            end
        end
    end

endmodule

// File: tb/tb_class_pio_master.sv
// Bench for class_pio_master: the bench acts as host and PIO responder, counts clk_div
// ticks itself and predicts bus phases and responses from tick numbers.
module tb_class_pio_master;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_vld;
    logic        req_rdy;
    logic        req_rw;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_vld;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic        pio_start;
    logic        pio_rw;
    logic [31:0] pio_addr_wdata;
    logic        clk_div;
    logic        pio_ack;
    logic        pio_rvalid;
    logic [31:0] pio_rdata;

    int   n_cmp = 0;
    int   n_err = 0;
    logic model_q;
    logic div_lvl;
    int   div_left;
    int   div_half;
    int   div_hold;
    logic last_rw;

    always #5 clk = ~clk;

    class_pio_master #(
        .PIO_NBITS(32),
        .TIMEOUT_TICKS(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_vld(req_vld),
        .req_rdy(req_rdy),
        .req_rw(req_rw),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_vld(rsp_vld),
        .rsp_err(rsp_err),
        .rsp_rdata(rsp_rdata),
        .pio_start(pio_start),
        .pio_rw(pio_rw),
        .pio_addr_wdata(pio_addr_wdata),
        .clk_div(clk_div),
        .pio_ack(pio_ack),
        .pio_rvalid(pio_rvalid),
        .pio_rdata(pio_rdata)
    );

    task automatic chk1(input logic obs, input logic exp, input string tag);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Pick this cycle's clk_div level and say whether it is a rising edge (tick)
    task automatic set_div(output logic is_tick);
        if (div_left <= 1) begin
            div_lvl = ~div_lvl;
            if (div_lvl && div_hold > 0) begin
                div_left = div_hold;
                div_hold = 0;
            end else begin
                div_left = div_half;
            end
        end else begin
            div_left--;
        end
        clk_div = div_lvl;
        is_tick = div_lvl & ~model_q;
    endtask

    task automatic clk_step();
        @(posedge clk);
        model_q = rst ? 1'b0 : clk_div;
        #1;
    endtask

    // Expected completion: wait-tick number of the response and whether it is a timeout
    task automatic exp_result(input logic rw, input int ack_n, input int rv_n,
                              output int wfin, output logic err);
        if (ack_n < 1 || ack_n > TO) begin
            wfin = TO;
            err  = 1'b1;
        end else if (rw || rv_n == 0) begin
            wfin = ack_n;
            err  = 1'b0;
        end else if (rv_n <= TO) begin
            wfin = ack_n + rv_n;
            err  = 1'b0;
        end else begin
            wfin = ack_n + TO;
            err  = 1'b1;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk1(req_rdy, 1'b0, {tag, "_rdy"});
        chk1(rsp_vld, 1'b0, {tag, "_rsp_vld"});
        chk1(rsp_err, 1'b0, {tag, "_rsp_err"});
        chk32(rsp_rdata, 32'h0, {tag, "_rsp_rdata"});
        chk1(pio_start, 1'b0, {tag, "_start"});
        chk1(pio_rw, 1'b0, {tag, "_rw"});
        chk32(pio_addr_wdata, 32'h0, {tag, "_bus"});
    endtask

    task automatic reset_midway();
        logic tk;
        rst = 1'b1;
        pio_ack = 1'b0;
        pio_rvalid = 1'b0;
        set_div(tk);
        clk_step();
        chk_all_zero("midrst");
        rst = 1'b0;
        last_rw = 1'b0;
        set_div(tk);
        clk_step();
        chk1(req_rdy, 1'b1, "midrst_rdy_after");
        for (int i = 0; i < 8; i++) begin
            pio_ack = 1'b1;
            pio_rvalid = 1'b1;
            pio_rdata = $urandom;
            set_div(tk);
            clk_step();
            chk1(rsp_vld, 1'b0, "midrst_late_rsp");
            chk1(pio_start, 1'b0, "midrst_late_start");
        end
        pio_ack = 1'b0;
        pio_rvalid = 1'b0;
    endtask

    // One host request; ack on wait tick ack_n (0 = never), rvalid rv_n ticks after ack
    task automatic run_txn(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int ack_n, input int rv_n,
                           input int half, input int hold, input int rst_wt);
        int          wfin;
        logic        err;
        logic [31:0] exp_rd;
        logic [31:0] exp_bus;
        int          ticks;
        int          cyc;
        int          wn;
        bit          done;
        logic        tk;
        div_half = half;
        div_hold = hold;
        exp_result(rw, ack_n, rv_n, wfin, err);
        exp_rd = (err || rw) ? 32'h0 : rdata;
        chk1(req_rdy, 1'b1, "rdy_before_req");
        req_vld = 1'b1;
        req_rw = rw;
        req_addr = addr;
        req_wdata = wdata;
        set_div(tk);
        pio_ack = 1'($urandom);
        pio_rvalid = 1'($urandom);
        pio_rdata = $urandom;
        clk_step();
        req_vld = 1'b0;
        req_rw = 1'($urandom);
        req_addr = $urandom;
        req_wdata = $urandom;
        ticks = 0;
        cyc = 0;
        done = 1'b0;
        while (!done) begin
            if (cyc > 400) begin
                n_cmp++;
                n_err++;
                $error("FAIL budget: observed no response after %0d cycles, expected one", cyc);
                done = 1'b1;
            end else if (rst_wt > 0 && ticks == 2 + rst_wt) begin
                reset_midway();
                done = 1'b1;
            end else if (ticks == 2 + wfin) begin
                chk1(rsp_vld, 1'b1, "rsp_vld");
                chk1(rsp_err, err, "rsp_err");
                chk32(rsp_rdata, exp_rd, "rsp_rdata");
                chk1(req_rdy, 1'b0, "rdy_in_rsp");
                chk1(pio_start, 1'b0, "start_in_rsp");
                chk32(pio_addr_wdata, 32'h0, "bus_in_rsp");
                last_rw = rw;
                set_div(tk);
                pio_ack = 1'($urandom);
                pio_rvalid = 1'($urandom);
                clk_step();
                chk1(rsp_vld, 1'b0, "rsp_one_cycle");
                chk1(req_rdy, 1'b1, "rdy_after_rsp");
                chk32(pio_addr_wdata, 32'h0, "bus_idle");
                done = 1'b1;
            end else begin
                if (ticks == 0) begin
                    exp_bus = 32'h0;
                end else if (ticks == 1 || !rw) begin
                    exp_bus = addr;
                end else begin
                    exp_bus = wdata;
                end
                chk1(rsp_vld, 1'b0, "rsp_early");
                chk1(req_rdy, 1'b0, "rdy_busy");
                chk1(pio_start, ticks == 1, "pio_start");
                chk1(pio_rw, (ticks >= 1) ? rw : last_rw, "pio_rw");
                chk32(pio_addr_wdata, exp_bus, "pio_bus");
                set_div(tk);
                if (tk && ticks >= 2) begin
                    wn = ticks - 1;
                    pio_ack = (wn == ack_n);
                    pio_rvalid = (wn == ack_n + rv_n);
                    pio_rdata = pio_rvalid ? rdata : $urandom;
                end else begin
                    pio_ack = 1'($urandom);
                    pio_rvalid = 1'($urandom);
                    pio_rdata = $urandom;
                end
                clk_step();
                if (tk) begin
                    ticks++;
                end
                cyc++;
            end
        end
        pio_ack = 1'b0;
        pio_rvalid = 1'b0;
    endtask

    initial begin
        logic tk;
        rst = 1'b1;
        req_vld = 1'b0;
        req_rw = 1'b0;
        req_addr = 32'h0;
        req_wdata = 32'h0;
        clk_div = 1'b0;
        pio_ack = 1'b0;
        pio_rvalid = 1'b0;
        pio_rdata = 32'h0;
        model_q = 1'b0;
        div_lvl = 1'b0;
        div_left = 1;
        div_half = 2;
        div_hold = 0;
        last_rw = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_div(tk);
            clk_step();
            chk_all_zero("reset");
        end
        rst = 1'b0;
        set_div(tk);
        clk_step();
        chk1(req_rdy, 1'b1, "rdy_after_reset");

        run_txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 2, 0, 2, 0, 0);
        run_txn(1'b0, 32'h0000_0024, 32'h0, 32'h1234_5678, 1, 3, 2, 0, 0);
        run_txn(1'b0, 32'h0000_0030, 32'h0, 32'hA5A5_A5A5, 1, 0, 1, 0, 0);
        run_txn(1'b1, 32'h0000_0040, 32'h0000_1111, 32'h0, 0, 0, 1, 0, 0);
        run_txn(1'b1, 32'h0000_0048, 32'hCAFE_F00D, 32'h0, 1, 0, 1, 0, 0);
        run_txn(1'b0, 32'h0000_0044, 32'h0, 32'h0000_5555, 0, 0, 2, 0, 0);
        run_txn(1'b1, 32'h0000_004C, 32'h1357_9BDF, 32'h0, TO, 0, 1, 0, 0);
        run_txn(1'b0, 32'h0000_0054, 32'h0, 32'h0000_0077, 2, TO, 1, 0, 0);
        run_txn(1'b0, 32'h0000_0058, 32'h0, 32'h0000_0099, 1, TO + 1, 1, 0, 0);
        run_txn(1'b1, 32'h0000_0050, 32'h0BAD_F00D, 32'h0, 1, 0, 1, 10, 0);
        run_txn(1'b0, 32'h0000_005C, 32'h0, 32'hFEED_0001, 1, 9, 2, 0, 3);
        run_txn(1'b1, 32'h0000_0060, 32'h2468_ACE0, 32'h0, 1, 0, 1, 0, 0);

        for (int k = 0; k < 25; k++) begin
            logic rw_k;
            int   hold_k;
            rw_k = 1'($urandom);
            hold_k = ($urandom_range(3, 0) == 0) ? int'($urandom_range(8, 3)) : 0;
            run_txn(rw_k, $urandom, $urandom, $urandom, int'($urandom_range(5, 0)),
                    int'($urandom_range(5, 0)), int'($urandom_range(3, 1)), hold_k, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
